ram_dp_param: RTL and testbench

RAM_DP_PARAM -- requirements
Module: ram_dp_param

---
 rtl/ram_dp_param.sv | 136 +++++++++++++
 tb/tb_ram_dp_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// Dual-port byte-lane RAM with post-reset clear and write-collision tracking.
// Define RAM_DP_PARAM_OUTREG_EN to add an output register (read latency 2).
module ram_dp_param #(
  parameter int ADDRWID = 9,
  parameter int DATAWID = 18,
  parameter int BYTEWID = 9
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         CENA,
  input  logic                         CENB,
  input  logic                         WENA,
  input  logic                         WENB,
  input  logic [DATAWID/BYTEWID-1:0]   WENBA,
  input  logic [DATAWID/BYTEWID-1:0]   WENBB,
  input  logic [ADDRWID-1:0]           AA,
  input  logic [ADDRWID-1:0]           AB,
  input  logic [DATAWID-1:0]           DA,
  input  logic [DATAWID-1:0]           DB,
  output logic [DATAWID-1:0]           QA,
  output logic [DATAWID-1:0]           QB,
  output logic                         BUSY,
  output logic                         COLL,
  output logic [15:0]                  COLL_CNT
);

  localparam int DEPTH = 2**ADDRWID;
  localparam int NLANE = DATAWID/BYTEWID;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [ADDRWID-1:0] ptr_q, ptr_d;
  logic [DATAWID-1:0] qa_q, qa_d;
  logic [DATAWID-1:0] qb_q, qb_d;
  logic               coll_q, coll_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [DATAWID-1:0] mem [DEPTH];

  logic             ready;
  logic             rd_a, rd_b;
  logic             wr_a, wr_b;
  logic [NLANE-1:0] lane_a, lane_b;

  always_comb begin
    ready   = (state_q == ST_READY);
    rd_a    = ready & ~CENA & WENA;
    rd_b    = ready & ~CENB & WENB;
    wr_a    = ready & ~CENA & ~WENA;
    wr_b    = ready & ~CENB & ~WENB;
    lane_a  = wr_a ? ~WENBA : '0;
    lane_b  = wr_b ? ~WENBB : '0;
    state_d = state_q;
    ptr_d   = ptr_q;
    if (!ready) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == '1) state_d = ST_READY;
    end
    // combinational array read before the edge gives read-first data
    qa_d   = rd_a ? mem[AA] : qa_q;
    qb_d   = rd_b ? mem[AB] : qb_q;
    coll_d = wr_a & wr_b & (AA == AB);
    cnt_d  = cnt_q;
    if (coll_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      qa_q    <= '0;
      qb_q    <= '0;
      coll_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      qa_q    <= qa_d;
      qb_q    <= qb_d;
      coll_q  <= coll_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage is never reset; port A is written last so it wins shared lanes.
  always_ff @(posedge CLK) begin
    if (!ready) begin
      if (RST_N) mem[ptr_q] <= '0;
    end else begin
      for (int j = 0; j < NLANE; j++) begin
        if (lane_b[j])
          mem[AB][j*BYTEWID +: BYTEWID] <= DB[j*BYTEWID +: BYTEWID];
        if (lane_a[j])
          mem[AA][j*BYTEWID +: BYTEWID] <= DA[j*BYTEWID +: BYTEWID];
      end
    end
  end

`ifdef RAM_DP_PARAM_OUTREG_EN
  logic [DATAWID-1:0] qa_o_q, qa_o_d;
  logic [DATAWID-1:0] qb_o_q, qb_o_d;
  logic               ena_q, enb_q;

  always_comb begin
    qa_o_d = ena_q ? qa_q : qa_o_q;
    qb_o_d = enb_q ? qb_q : qb_o_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ena_q  <= 1'b0;
      enb_q  <= 1'b0;
      qa_o_q <= '0;
      qb_o_q <= '0;
    end else begin
      ena_q  <= rd_a;
      enb_q  <= rd_b;
      qa_o_q <= qa_o_d;
      qb_o_q <= qb_o_d;
    end
  end

  assign QA = qa_o_q;
  assign QB = qb_o_q;
`else
  assign QA = qa_q;
  assign QB = qb_q;
`endif

  assign BUSY     = (state_q == ST_INIT);
  assign COLL     = coll_q;
  assign COLL_CNT = cnt_q;

endmodule

// File: tb/tb_ram_dp_param.sv
// Randomized bench for ram_dp_param against an array-based memory model.
module tb_ram_dp_param;

  localparam int AW    = 9;
  localparam int DW    = 18;
  localparam int BW    = 9;
  localparam int NL    = 2;
  localparam int DEPTH = 512;
`ifdef RAM_DP_PARAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CENA = 1'b1, CENB = 1'b1;
  logic          WENA = 1'b1, WENB = 1'b1;
  logic [NL-1:0] WENBA = '1, WENBB = '1;
  logic [AW-1:0] AA = '0, AB = '0;
  logic [DW-1:0] DA = '0, DB = '0;
  logic [DW-1:0] QA, QB;
  logic          BUSY, COLL;
  logic [15:0]   COLL_CNT;

  always #5 CLK = ~CLK;

  ram_dp_param #(.ADDRWID(AW), .DATAWID(DW), .BYTEWID(BW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CENA(CENA), .CENB(CENB),
    .WENA(WENA), .WENB(WENB),
    .WENBA(WENBA), .WENBB(WENBB),
    .AA(AA), .AB(AB),
    .DA(DA), .DB(DB),
    .QA(QA), .QB(QB),
    .BUSY(BUSY), .COLL(COLL),
    .COLL_CNT(COLL_CNT)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] cur_a, cur_b, exp_a, exp_b;
  int            cnt_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic port_a(input logic cen, input logic wen,
                        input logic [1:0] m, input logic [8:0] a,
                        input logic [17:0] d);
    CENA = cen; WENA = wen; WENBA = m; AA = a; DA = d;
  endtask

  task automatic port_b(input logic cen, input logic wen,
                        input logic [1:0] m, input logic [8:0] a,
                        input logic [17:0] d);
    CENB = cen; WENB = wen; WENBB = m; AB = a; DB = d;
  endtask

  task automatic idle();
    CENA = 1'b1; CENB = 1'b1; WENA = 1'b1; WENB = 1'b1;
  endtask

  // one READY cycle: model the edge, then check every output
  task automatic step();
    logic [DW-1:0] ra, rb, oa, ob;
    bit wa, wb, rda, rdb, c;
    wa  = !CENA && !WENA;
    wb  = !CENB && !WENB;
    rda = !CENA && WENA;
    rdb = !CENB && WENB;
    ra  = model[AA];
    rb  = model[AB];
    c   = wa && wb && (AA == AB);
    for (int j = 0; j < NL; j++) begin
      if (wa && !WENBA[j])
        model[AA][j*BW +: BW] = DA[j*BW +: BW];
      if (wb && !WENBB[j] && !(c && !WENBA[j]))
        model[AB][j*BW +: BW] = DB[j*BW +: BW];
    end
    @(posedge CLK); #1;
    oa = cur_a;
    ob = cur_b;
    if (rda) cur_a = ra;
    if (rdb) cur_b = rb;
    exp_a = (LAT == 1) ? cur_a : oa;
    exp_b = (LAT == 1) ? cur_b : ob;
    if (c && cnt_m < 65535) cnt_m++;
    chk("qa", QA, exp_a);
    chk("qb", QB, exp_b);
    chk("coll", COLL, c);
    chk("coll_cnt", COLL_CNT, cnt_m[15:0]);
    chk("busy", BUSY, 1'b0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    chk("rst_qa", QA, 0);
    chk("rst_qb", QB, 0);
    chk("rst_busy", BUSY, 1);
    chk("rst_coll", COLL, 0);
    chk("rst_cnt", COLL_CNT, 0);
    cur_a = '0; cur_b = '0; exp_a = '0; exp_b = '0;
    cnt_m = 0;
    repeat (2) @(posedge CLK);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    while (BUSY && n < 2000) begin
      port_a(1'($urandom), 1'($urandom), 2'($urandom),
             9'($urandom), 18'($urandom));
      port_b(1'($urandom), 1'($urandom), 2'($urandom),
             9'($urandom), 18'($urandom));
      @(posedge CLK); #1;
      n++;
    end
    idle();
    chk("busy_len", n, DEPTH);
    chk("init_qa", QA, 0);
    chk("init_qb", QB, 0);
    chk("init_coll", COLL, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    cur_a = '0; cur_b = '0; exp_a = '0; exp_b = '0; cnt_m = 0;
    do_reset();
    wait_init();

    port_a(0, 1, 2'b11, 9'h000, 0); step();
    port_a(0, 1, 2'b11, 9'h1FF, 0); step();
    idle(); repeat (LAT) step();
    chk("rd_1ff", QA, 0);

    port_a(0, 0, 2'b00, 9'h010, 18'h2AAAA); step();
    idle(); port_b(0, 1, 2'b11, 9'h010, 0); step();
    idle(); repeat (LAT - 1) step();
    chk("wr_rd_b", QB, 18'h2AAAA);

    port_a(0, 0, 2'b00, 9'h020, 18'h3FFFF); step();
    port_a(0, 0, 2'b10, 9'h020, 18'h00000); step();
    port_a(0, 1, 2'b11, 9'h020, 0); step();
    idle(); repeat (LAT - 1) step();
    chk("lane_mask", QA, 18'h3FE00);

    port_a(0, 0, 2'b00, 9'h005, 18'h11111);
    port_b(0, 0, 2'b01, 9'h005, 18'h22222);
    step();
    chk("coll_pulse", COLL, 1);
    idle(); step();
    chk("coll_drop", COLL, 0);
    chk("coll_cnt1", COLL_CNT, 1);
    port_a(0, 1, 2'b11, 9'h005, 0); step();
    idle(); repeat (LAT - 1) step();
    chk("coll_word", QA, 18'h11111);

    port_a(0, 0, 2'b00, 9'h007, 18'h12345);
    port_b(0, 1, 2'b11, 9'h007, 0);
    step();
    idle(); repeat (LAT - 1) step();
    chk("read_first", QB, 0);
    port_b(0, 1, 2'b11, 9'h007, 0); step();
    idle(); repeat (LAT - 1) step();
    chk("read_after", QB, 18'h12345);

    port_a(0, 0, 2'b00, 9'h030, 18'h00001);
    port_b(0, 0, 2'b00, 9'h031, 18'h00002);
    step();
    chk("diff_addr_coll", COLL, 0);
    port_a(0, 1, 2'b11, 9'h030, 0);
    port_b(0, 1, 2'b11, 9'h031, 0);
    step();
    idle(); repeat (LAT - 1) step();
    chk("diff_a", QA, 18'h00001);
    chk("diff_b", QB, 18'h00002);

    repeat (2) begin
      port_a(0, 0, 2'b11, 9'h009, 18'h3FFFF);
      port_b(0, 0, 2'b11, 9'h009, 18'h3FFFF);
      step();
      idle(); step();
    end
    chk("coll_cnt3", COLL_CNT, 3);

    do_reset();
    wait_init();

    @(negedge CLK);
    RST_N = 1'b1;
    repeat (100) @(posedge CLK);
    #1;
    do_reset();
    wait_init();

    repeat (1500) begin
      port_a(1'($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom),
             9'($urandom_range(0, 15)), 18'($urandom));
      port_b(1'($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom),
             9'($urandom_range(0, 15)), 18'($urandom));
      step();
    end
    idle(); repeat (LAT) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
